// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: result source tags and default sizing.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2,
    WB_SRC_MDU  = 2'd3
  } wb_src_e;

  localparam int WB_XLEN    = 64;
  localparam int WB_STARVE  = 4;
  localparam int WB_CNT_W   = 3;
  localparam int WB_NREGS   = 32;

endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// Busy vector of GPRs waiting on a long-latency (LSU/MDU) result.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_rd,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_rd,
  output logic [31:0] o_busy
);

  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;

  // Clear applied before set so a newly issued op on the same rd stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (i_clr_en)
        w_busy_nxt[i_clr_rd] = 1'b0;
      if (i_set_en)
        w_busy_nxt[i_set_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/wb_arbiter.sv
// GPR writeback arbiter: one result per cycle from ALU/LSU/MDU with
// starvation promotion, registered write port and busy scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int STARVE_LIMIT = WB_STARVE,
  parameter int CNT_W        = WB_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            sb_set_en,
  input  logic [4:0]      sb_set_rd,
  output logic [4:0]      rd,
  output logic            rd_w_en,
  output logic            rd_idx_0,
  output logic [XLEN-1:0] x_rd,
  output logic [31:0]     busy,
  output logic [1:0]      wb_src
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] SAT = '1;

  logic [CNT_W-1:0] r_cnt_alu, r_cnt_lsu, r_cnt_mdu;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_x_rd;
  logic             r_w_en;
  logic             r_idx_0;
  wb_src_e          r_src;

  wb_src_e          w_gnt;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_data;
  logic             w_xfer;
  logic             w_clr_en;

  function automatic logic [CNT_W-1:0] f_cnt(
    input logic             v,
    input logic             g,
    input logic [CNT_W-1:0] c
  );
    if (!v || g || flush)
      return '0;
    return (c == SAT) ? c : c + 1'b1;
  endfunction

  // Starved sources first, then default LSU > MDU > ALU.
  always_comb begin
    w_gnt = WB_SRC_NONE;
    if (!rst && !flush) begin
      if (lsu_valid && r_cnt_lsu >= LIM)      w_gnt = WB_SRC_LSU;
      else if (mdu_valid && r_cnt_mdu >= LIM) w_gnt = WB_SRC_MDU;
      else if (alu_valid && r_cnt_alu >= LIM) w_gnt = WB_SRC_ALU;
      else if (lsu_valid)                     w_gnt = WB_SRC_LSU;
      else if (mdu_valid)                     w_gnt = WB_SRC_MDU;
      else if (alu_valid)                     w_gnt = WB_SRC_ALU;
    end
  end

  always_comb begin
    w_rd   = '0;
    w_data = '0;
    unique case (1'b1)
      (w_gnt == WB_SRC_LSU): begin w_rd = lsu_rd; w_data = lsu_data; end
      (w_gnt == WB_SRC_MDU): begin w_rd = mdu_rd; w_data = mdu_data; end
      (w_gnt == WB_SRC_ALU): begin w_rd = alu_rd; w_data = alu_data; end
      default: ;
    endcase
  end

  assign alu_ready = (w_gnt == WB_SRC_ALU);
  assign lsu_ready = (w_gnt == WB_SRC_LSU);
  assign mdu_ready = (w_gnt == WB_SRC_MDU);
  assign w_xfer    = (w_gnt != WB_SRC_NONE);
  assign w_clr_en  = lsu_ready || mdu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_alu <= '0;
      r_cnt_lsu <= '0;
      r_cnt_mdu <= '0;
      r_rd      <= '0;
      r_x_rd    <= '0;
      r_w_en    <= 1'b0;
      r_idx_0   <= 1'b1;
      r_src     <= WB_SRC_NONE;
    end else begin
      r_cnt_alu <= f_cnt(alu_valid, alu_ready, r_cnt_alu);
      r_cnt_lsu <= f_cnt(lsu_valid, lsu_ready, r_cnt_lsu);
      r_cnt_mdu <= f_cnt(mdu_valid, mdu_ready, r_cnt_mdu);
      r_w_en    <= w_xfer;
      r_src     <= w_gnt;
      if (w_xfer) begin
        r_rd    <= w_rd;
        r_x_rd  <= w_data;
        r_idx_0 <= (w_rd == 5'd0);
      end
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush),
    .i_set_en (sb_set_en),
    .i_set_rd (sb_set_rd),
    .i_clr_en (w_clr_en),
    .i_clr_rd (w_rd),
    .o_busy   (busy)
  );

  assign rd       = r_rd;
  assign x_rd     = r_x_rd;
  assign rd_w_en  = r_w_en;
  assign rd_idx_0 = r_idx_0;
  assign wb_src   = r_src;

endmodule
